// File: rtl/calc_pkg.sv
// Shared calculator definitions: sequencer state encoding and datapath width,
// used by the multiplier, the divider and the calculator top.
package calc_pkg;

  localparam int unsigned CALC_WIDTH = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StCalc = 2'd2,
    StDone = 2'd3
  } calc_state_e;

endpackage

// File: rtl/mult_16_ctrl.sv
// Sequencer for the shift-add multiplier: start edge detect, step counter,
// registered done/busy, and load/step/finish strobes for the datapath.
module mult_16_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic init_in,
  output logic load,
  output logic step,
  output logic finish,
  output logic done,
  output logic busy
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  calc_state_e     state_q;
  logic            init_q;
  logic [CntW-1:0] cnt_q;
  logic            done_q;
  logic            busy_q;
  logic            start;
  logic            last;

  // Only a fresh rising edge seen while idle starts work; edges during an
  // operation are dropped, not queued.
  assign start  = init_in & ~init_q & (state_q == StIdle);
  assign last   = (cnt_q == CntW'(WIDTH - 1));

  assign load   = (state_q == StLoad);
  assign step   = (state_q == StCalc);
  assign finish = step & last;
  assign done   = done_q;
  assign busy   = busy_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      init_q  <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      init_q <= init_in;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLoad;
            busy_q  <= 1'b1;
          end
        end
        StLoad: begin
          state_q <= StCalc;
          cnt_q   <= '0;
        end
        StCalc: begin
          cnt_q <= cnt_q + CntW'(1);
          if (last) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: rtl/mult_16.sv
// Sequential unsigned shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, with
// the same init_in/done handshake as the divider and a display-overflow flag.
module mult_16
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init_in,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] Result,
  output logic               done,
  output logic               busy,
  output logic               ovf
);

  logic               load;
  logic               step;
  logic               finish;

  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ovf_q;

  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;
  logic               unused_acc_lsb;

  mult_16_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .init_in (init_in),
    .load    (load),
    .step    (step),
    .finish  (finish),
    .done    (done),
    .busy    (busy)
  );

  // Add into the upper half, then shift the whole accumulator right; the
  // carry of the add becomes the new MSB.
  always_comb begin
    addend   = mplier_q[0] ? {1'b0, mcand_q} : '0;
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + addend;
    acc_step = {sum, acc_q[WIDTH-1:1]};
  end

  // The bit shifted out on each step is discarded by design.
  assign unused_acc_lsb = acc_q[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (load) begin
        mcand_q  <= A;
        mplier_q <= B;
        acc_q    <= '0;
      end else if (step) begin
        acc_q    <= acc_step;
        mplier_q <= mplier_q >> 1;
      end
      // Capture the final step directly so Result is valid in the done cycle.
      if (finish) begin
        result_q <= acc_step;
        ovf_q    <= |acc_step[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign Result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_mult_16.sv
// Self-checking bench for mult_16: table of directed and random vectors
// against a plain-arithmetic model, plus hand-written handshake sequences.
module tb_mult_16;
  import calc_pkg::*;

  localparam int unsigned W       = CALC_WIDTH;
  localparam int unsigned Latency = 18;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] res;
    logic           ovf;
  } vec_t;

  logic           clk     = 1'b0;
  logic           rst     = 1'b0;
  logic           init_in = 1'b0;
  logic [W-1:0]   A       = '0;
  logic [W-1:0]   B       = '0;
  logic [2*W-1:0] Result;
  logic           done;
  logic           busy;
  logic           ovf;

  int             n_vec    = 0;
  int             n_bad    = 0;
  logic [2*W-1:0] exp_last = '0;
  vec_t           vecs[$];

  always #5 clk = ~clk;

  mult_16 #(
    .WIDTH (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .init_in (init_in),
    .A       (A),
    .B       (B),
    .Result  (Result),
    .done    (done),
    .busy    (busy),
    .ovf     (ovf)
  );

  function automatic logic [2*W-1:0] model_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return p[2*W-1:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One operation with a two-cycle init_in pulse; checks latency, busy,
  // result hold before completion, result, ovf and the done pulse width.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] er, input logic eo, input string tag);
    int   edges;
    logic got;
    edges = 0;
    got   = 1'b0;
    @(negedge clk);
    A       = a;
    B       = b;
    init_in = 1'b1;
    while (!got && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 2) init_in = 1'b0;
      if (edges == 1) check({tag, "_busy_load"}, 32'(busy), 32'd1);
      if (edges == 10) check({tag, "_hold_prev"}, Result, exp_last);
      if (done) got = 1'b1;
    end
    check({tag, "_latency"}, 32'(edges), 32'(Latency));
    check({tag, "_result"}, Result, er);
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_result_held"}, Result, er);
    exp_last = er;
  endtask

  initial begin
    int          pulses;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // Directed table, expected values written out by hand.
    vecs.push_back('{a: 16'h012C, b: 16'h0032, res: 32'h0000_3A98, ovf: 1'b0});
    vecs.push_back('{a: 16'hFFFF, b: 16'hFFFF, res: 32'hFFFE_0001, ovf: 1'b1});
    vecs.push_back('{a: 16'h0000, b: 16'h1234, res: 32'h0000_0000, ovf: 1'b0});
    vecs.push_back('{a: 16'h8000, b: 16'h0002, res: 32'h0001_0000, ovf: 1'b1});
    vecs.push_back('{a: 16'h1234, b: 16'h0000, res: 32'h0000_0000, ovf: 1'b0});
    vecs.push_back('{a: 16'h0001, b: 16'hFFFF, res: 32'h0000_FFFF, ovf: 1'b0});
    vecs.push_back('{a: 16'h0100, b: 16'h0100, res: 32'h0001_0000, ovf: 1'b1});
    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i < 4) rb = rb & 16'h00FF;
      vecs.push_back('{a: ra, b: rb, res: model_mul(ra, rb),
                       ovf: (model_mul(ra, rb) >> W) != 0});
    end

    // Reset state.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", Result, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Table sweep; consecutive entries also exercise back-to-back starts.
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf, $sformatf("vec%0d", i));
    end

    // init_in held high: exactly one operation.
    @(negedge clk);
    A       = 16'd7;
    B       = 16'd6;
    init_in = 1'b1;
    pulses  = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("hold_pulses", 32'(pulses), 32'd1);
    check("hold_result", Result, 32'd42);
    exp_last = 32'd42;
    @(negedge clk);
    init_in = 1'b0;
    run_op(16'd9, 16'd9, 32'd81, 1'b0, "hold_restart");

    // Edge on init_in and operand changes during CALC are ignored.
    @(negedge clk);
    A       = 16'h0100;
    B       = 16'h0100;
    init_in = 1'b1;
    pulses  = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
      if (i == 5) init_in = 1'b0;
      if (i == 6) begin
        init_in = 1'b1;
        A       = 16'hFFFF;
        B       = 16'hFFFF;
      end
    end
    check("toggle_pulses", 32'(pulses), 32'd1);
    check("toggle_result", Result, 32'h0001_0000);
    check("toggle_ovf", 32'(ovf), 32'd1);
    exp_last = 32'h0001_0000;
    @(negedge clk);
    init_in = 1'b0;

    // Reset in the 8th CALC cycle aborts the operation.
    @(negedge clk);
    A       = 16'd300;
    B       = 16'd50;
    init_in = 1'b1;
    pulses  = 0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) init_in = 1'b0;
      if (done) pulses++;
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", Result, 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    exp_last = 32'd0;
    run_op(16'd3, 16'd5, 32'd15, 1'b0, "after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
